dmux_sched: RTL and testbench

- Round-robin burst scheduler that sequences a registered 1-to-N_DEST demultiplexer.
- Accepts one valid/ready input stream and grants it to one enabled destination at a time, for a burst of BURST words.
- Then advances the select to the next enabled destination.
- Sits between a single producer and N_DEST consumers that share one data bus.

---
 rtl/dmux_sched_pkg.sv | 15 +
 rtl/dmux_sched_rr_pick.sv | 30 +++
 rtl/dmux_sched.sv | 164 ++++++++++++++++
 tb/tb_dmux_sched.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmux_sched_pkg.sv
// Shared types and helpers for the dmux_sched round-robin burst scheduler.
package dmux_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_XFER  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Select width; never narrower than one bit.
    function automatic int sel_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dmux_sched_rr_pick.sv
// Combinational round-robin finder: first set mask bit after cur, wrapping;
// cur itself is chosen last so a lone enabled destination is re-picked.
module rr_pick
    import dmux_sched_pkg::*;
#(
    parameter int N_DEST = 4
) (
    input  logic [N_DEST-1:0]        mask,
    input  logic [sel_w(N_DEST)-1:0] cur,
    output logic [sel_w(N_DEST)-1:0] nxt,
    output logic                     any
);

    localparam int SW = sel_w(N_DEST);

    always_comb begin
        logic [SW-1:0] idx;
        idx = '0;
        nxt = cur;
        any = |mask;
        // Descending offset so the nearest enabled index is the final assignment.
        for (int k = N_DEST; k >= 1; k--) begin
            idx = SW'((int'(cur) + k) % N_DEST);
            if (mask[idx]) begin
                nxt = idx;
            end
        end
    end

endmodule

// File: rtl/dmux_sched.sv
// Round-robin burst scheduler driving a registered 1-to-N_DEST demux.
// Optional stall watchdog enabled by defining DMUX_SCHED_WDOG_EN.
//
// state    | meaning
// ST_IDLE  | no destination enabled, nothing granted
// ST_XFER  | accepting up to BURST words for cur_sel
// ST_DRAIN | burst accepted, waiting for the output register to empty
module dmux_sched
    import dmux_sched_pkg::*;
#(
    parameter int N_DEST = 4,
    parameter int DW     = 8,
    parameter int BURST  = 4
`ifdef DMUX_SCHED_WDOG_EN
    , parameter int TIMEOUT = 16
`endif
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_DEST-1:0]        cfg_en,
    input  logic                     in_valid,
    input  logic [DW-1:0]            in_data,
    output logic                     in_ready,
    output logic [N_DEST-1:0]        out_valid,
    output logic [DW-1:0]            out_data,
    input  logic [N_DEST-1:0]        out_ready,
    output logic [sel_w(N_DEST)-1:0] cur_sel,
    output logic                     busy
`ifdef DMUX_SCHED_WDOG_EN
    , output logic                   timeout_pulse
`endif
);

    localparam int SW = sel_w(N_DEST);
    localparam int CW = $clog2(BURST + 1);

    state_t        r_state;
    logic [SW-1:0] r_sel;
    logic [CW-1:0] r_cnt;
    logic          r_full;
    logic [DW-1:0] r_data;

    logic [SW-1:0] w_pick;
    logic          w_any;
    logic          w_dst_rdy;
    logic          w_out_hs;
    logic          w_in_ready;
    logic          w_in_hs;
    logic          w_last;
    logic          w_drain_done;
    logic          w_tmo;

    rr_pick #(.N_DEST(N_DEST)) u_pick (
        .mask (cfg_en),
        .cur  (r_sel),
        .nxt  (w_pick),
        .any  (w_any)
    );

    assign w_dst_rdy    = out_ready[r_sel];
    assign w_out_hs     = r_full && w_dst_rdy;
    assign w_in_ready   = (r_state == ST_XFER) && (!r_full || w_dst_rdy) && (r_cnt < CW'(BURST));
    assign w_in_hs      = in_valid && w_in_ready;
    assign w_last       = w_in_hs && (r_cnt == CW'(BURST - 1));
    assign w_drain_done = (r_state == ST_DRAIN) && (!r_full || w_out_hs);

`ifdef DMUX_SCHED_WDOG_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] r_stall;
    logic          r_tmo_pulse;
    logic          w_stall;
    logic          w_pick_now;

    assign w_stall    = r_full && !w_dst_rdy && (r_state != ST_IDLE);
    assign w_tmo      = w_stall && (r_stall == TW'(TIMEOUT - 1));
    assign w_pick_now = ((r_state == ST_IDLE) || w_drain_done) && w_any;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall     <= '0;
            r_tmo_pulse <= 1'b0;
        end else begin
            r_tmo_pulse <= w_tmo;
            if (w_out_hs || w_pick_now || w_tmo) begin
                r_stall <= '0;
            end else if (w_stall) begin
                r_stall <= r_stall + 1'b1;
            end
        end
    end

    assign timeout_pulse = r_tmo_pulse;
`else
    assign w_tmo = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_sel   <= SW'(N_DEST - 1);
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_sel   <= w_pick;
                        r_cnt   <= '0;
                        r_state <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    // A watchdog drop abandons the rest of the burst.
                    if (w_tmo) begin
                        r_state <= ST_DRAIN;
                    end else if (w_in_hs) begin
                        r_cnt <= r_cnt + 1'b1;
                        if (w_last) begin
                            r_state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (w_drain_done) begin
                        if (w_any) begin
                            r_sel   <= w_pick;
                            r_cnt   <= '0;
                            r_state <= ST_XFER;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // One-entry output register; a same-edge in/out handshake simply reloads it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_full <= 1'b0;
            r_data <= '0;
        end else if (w_in_hs) begin
            r_full <= 1'b1;
            r_data <= in_data;
        end else if (w_out_hs || w_tmo) begin
            r_full <= 1'b0;
        end
    end

    always_comb begin
        out_valid = '0;
        if (r_full) begin
            out_valid[r_sel] = 1'b1;
        end
    end

    assign in_ready = w_in_ready;
    assign out_data = r_data;
    assign cur_sel  = r_sel;
    assign busy     = (r_state != ST_IDLE);

endmodule

// File: tb/tb_dmux_sched.sv
// Self-checking bench for dmux_sched: directed phases plus random traffic,
// compared every cycle against a transaction-level burst model.
module tb_dmux_sched;

    localparam int N       = 4;
    localparam int DW      = 8;
    localparam int BURST   = 4;
    localparam int TIMEOUT = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  cfg_en;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic [N-1:0]  out_valid;
    logic [DW-1:0] out_data;
    logic [N-1:0]  out_ready;
    logic [1:0]    cur_sel;
    logic          busy;
`ifdef DMUX_SCHED_WDOG_EN
    logic          timeout_pulse;
`endif

    dmux_sched u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cfg_en        (cfg_en),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_ready      (in_ready),
        .out_valid     (out_valid),
        .out_data      (out_data),
        .out_ready     (out_ready),
        .cur_sel       (cur_sel),
        .busy          (busy)
`ifdef DMUX_SCHED_WDOG_EN
        , .timeout_pulse (timeout_pulse)
`endif
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: a granted destination, words still owed in its burst,
    // and the contents of the one-word output holding register.
    bit            m_busy;
    int            m_dest;
    int            m_left;
    bit            m_full;
    logic [DW-1:0] m_data;
    int            m_stall;
    bit            m_tmo;

    function automatic int next_dest(input logic [N-1:0] mask, input int from);
        for (int k = 1; k <= N; k++) begin
            if (mask[(from + k) % N]) return (from + k) % N;
        end
        return from;
    endfunction

    task automatic model_reset();
        m_busy  = 1'b0;
        m_dest  = N - 1;
        m_left  = 0;
        m_full  = 1'b0;
        m_data  = '0;
        m_stall = 0;
        m_tmo   = 1'b0;
    endtask

    task automatic model_edge();
        bit rdy, in_hs, out_hs, done;
        m_tmo = 1'b0;
        if (!m_busy) begin
            if (cfg_en != 0) begin
                m_dest  = next_dest(cfg_en, m_dest);
                m_left  = BURST;
                m_busy  = 1'b1;
                m_stall = 0;
            end
            return;
        end
        rdy    = (m_left > 0) && (!m_full || out_ready[m_dest]);
        in_hs  = in_valid && rdy;
        out_hs = m_full && out_ready[m_dest];
        done   = (m_left == 0) && (!m_full || out_hs);
`ifdef DMUX_SCHED_WDOG_EN
        if (m_full && !out_ready[m_dest]) begin
            m_stall++;
            if (m_stall == TIMEOUT) begin
                m_full  = 1'b0;
                m_left  = 0;
                m_tmo   = 1'b1;
                m_stall = 0;
                return;
            end
        end else begin
            m_stall = 0;
        end
`endif
        if (in_hs) begin
            m_full = 1'b1;
            m_data = in_data;
            m_left--;
        end else if (out_hs) begin
            m_full = 1'b0;
        end
        if (done) begin
            if (cfg_en != 0) begin
                m_dest  = next_dest(cfg_en, m_dest);
                m_left  = BURST;
                m_stall = 0;
            end else begin
                m_busy = 1'b0;
            end
        end
    endtask

    task automatic check_outputs();
        bit exp_rdy;
        exp_rdy = m_busy && (m_left > 0) && (!m_full || out_ready[m_dest]);
        chk("in_ready",  32'(in_ready),  32'(exp_rdy));
        chk("out_valid", 32'(out_valid), m_full ? (32'd1 << m_dest) : 32'd0);
        chk("out_data",  32'(out_data),  32'(m_data));
        chk("cur_sel",   32'(cur_sel),   32'(m_dest));
        chk("busy",      32'(busy),      32'(m_busy));
`ifdef DMUX_SCHED_WDOG_EN
        chk("timeout_pulse", 32'(timeout_pulse), 32'(m_tmo));
`endif
    endtask

    // Entered at posedge+1 with fresh inputs; leaves at the next posedge+1.
    task automatic cycle();
        #1;
        check_outputs();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        bit cleared;
        rst_n     = 1'b1;
        cfg_en    = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = '0;
        model_reset();
        #1 rst_n = 1'b0;
        #2;
        check_outputs();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Two enabled destinations, full-rate traffic.
        cfg_en    = 4'b0101;
        in_valid  = 1'b1;
        out_ready = 4'b1111;
        for (int i = 0; i < 30; i++) begin
            in_data = DW'($urandom);
            cycle();
        end

        // Nothing enabled: drain and idle, then a single high destination.
        cfg_en = 4'b0000;
        for (int i = 0; i < 8; i++) begin
            in_data = DW'($urandom);
            cycle();
        end
        cfg_en = 4'b1000;
        for (int i = 0; i < 8; i++) begin
            in_data = DW'($urandom);
            cycle();
        end

        // Stalled destination mid-burst, then release.
        cfg_en = 4'b0010;
        for (int i = 0; i < 6; i++) begin
            in_data = DW'($urandom);
            cycle();
        end
        out_ready = 4'b1101;
        for (int i = 0; i < 5; i++) begin
            in_data = DW'($urandom);
            cycle();
        end
        out_ready = 4'b1111;
        for (int i = 0; i < 12; i++) begin
            in_data = DW'($urandom);
            cycle();
        end

        // Disable the current destination partway through its burst.
        cfg_en  = 4'b1001;
        cleared = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (!cleared && m_busy && m_dest == 3 && m_left == 2) begin
                cfg_en  = 4'b0001;
                cleared = 1'b1;
            end
            in_data = DW'($urandom);
            cycle();
        end
        chk("mask_cleared_mid_burst", 32'(cleared), 32'd1);

        // Asynchronous reset in the middle of a burst.
        cfg_en = 4'b0110;
        for (int i = 0; i < 3; i++) begin
            in_data = DW'($urandom);
            cycle();
        end
        rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", 32'(out_valid), 32'd0);
        chk("async_rst_busy",      32'(busy),      32'd0);
        chk("async_rst_in_ready",  32'(in_ready),  32'd0);
        chk("async_rst_cur_sel",   32'(cur_sel),   32'd3);
        model_reset();
        #1 rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_data = DW'($urandom);
            cycle();
        end

        // Random traffic, occasional mask changes.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 29) == 0) cfg_en = N'($urandom_range(0, 15));
            in_valid = ($urandom_range(0, 3) != 0);
            for (int b = 0; b < N; b++) out_ready[b] = ($urandom_range(0, 3) != 0);
            in_data = DW'($urandom);
            cycle();
        end

`ifdef DMUX_SCHED_WDOG_EN
        // Permanently stalled destination 0: the watchdog must drop and move on.
        begin
            int pulses;
            pulses    = 0;
            cfg_en    = 4'b0011;
            in_valid  = 1'b1;
            out_ready = 4'b1110;
            for (int i = 0; i < 80; i++) begin
                in_data = DW'($urandom);
                cycle();
                if (m_tmo) pulses++;
            end
            chk("wdog_pulses_seen", 32'(pulses > 0), 32'd1);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
